sigmoid_pipe_array: RTL and testbench

Parametrised, multi-channel successor to the single-channel 16-bit sigmoid activation and sigmoid-prime units. Each accepted input beat carries CH signed fixed-point neuron signals. Every lane produces sigma(x) using the PLAN piecewise-linear approximation and sigma'(x) = y*(1-y). The block is a 3-stage pipeline with valid/ready handshakes on both sides and a saturation statistics counter. It sits between the weighted-sum accumulator (or the LFSR weight generator in bring-up) and the layer output buffer.

---
 rtl/sigmoid_pkg.sv | 35 +++
 rtl/sigmoid_plan_lane.sv | 129 ++++++++++++
 rtl/sigmoid_pipe_array.sv | 90 +++++++++
 tb/tb_sigmoid_pipe_array.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sigmoid_pkg.sv
// Shared constants for the PLAN sigmoid datapath.
// Purpose: derives ONE, segment thresholds and segment offsets from FRAC, plus segment codes.
// Contents: plan_consts_t / plan_consts(), SEG_S0..SEG_S3.
package sigmoid_pkg;

  // Segment codes produced in stage 1 and consumed in stage 2.
  localparam logic [1:0] SEG_S0 = 2'd0;
  localparam logic [1:0] SEG_S1 = 2'd1;
  localparam logic [1:0] SEG_S2 = 2'd2;
  localparam logic [1:0] SEG_S3 = 2'd3;

  // All values are in the Q.FRAC domain, kept 32 bits wide and narrowed by the user.
  typedef struct packed {
    logic [31:0] one;
    logic [31:0] thr_s1;   // 1.0
    logic [31:0] thr_s2;   // 2.375
    logic [31:0] thr_s3;   // 5.0
    logic [31:0] off_s0;   // 0.5
    logic [31:0] off_s1;   // 0.625
    logic [31:0] off_s2;   // 0.84375
  } plan_consts_t;

  function automatic plan_consts_t plan_consts(input int frac);
    plan_consts_t c;
    c.one    = 32'(1) << frac;
    c.thr_s1 = c.one;
    c.thr_s2 = 32'(19) << (frac - 3);
    c.thr_s3 = 32'(5) * c.one;
    c.off_s0 = c.one >> 1;
    c.off_s1 = (32'(5) * c.one) >> 3;
    c.off_s2 = (32'(27) * c.one) >> 5;
    return c;
  endfunction

endpackage

// File: rtl/sigmoid_plan_lane.sv
// One lane of the PLAN sigmoid: sigma(x) and sigma'(x) = y*(1-y).
// Latency: 3 register stages, all advancing together on adv; sat is combinational from x.
// Backpressure: every stage holds its contents while adv is low.
// Ports: clk, rst (sync, active high), adv (stage enable), x (signed Q.FRAC),
//        y = sigma(x), dy = sigma'(x), sat = |x| >= 5.0 for the beat currently on x.
module sigmoid_plan_lane
  import sigmoid_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int FRAC  = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             adv,
  input  logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] dy,
  output logic             sat
);

  localparam plan_consts_t PC = plan_consts(FRAC);
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(PC.one);
  localparam logic [WIDTH-1:0] THR_S1   = WIDTH'(PC.thr_s1);
  localparam logic [WIDTH-1:0] THR_S2   = WIDTH'(PC.thr_s2);
  localparam logic [WIDTH-1:0] THR_S3   = WIDTH'(PC.thr_s3);
  localparam logic [WIDTH-1:0] OFF_S0   = WIDTH'(PC.off_s0);
  localparam logic [WIDTH-1:0] OFF_S1   = WIDTH'(PC.off_s1);
  localparam logic [WIDTH-1:0] OFF_S2   = WIDTH'(PC.off_s2);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] MAX_POS  = {1'b0, {(WIDTH-1){1'b1}}};

  // Stage 1 state
  logic             sign_q, sign_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [1:0]       seg_q, seg_d;
  // Stage 2 state
  logic [WIDTH-1:0] y2_q, y2_d;
  // Stage 3 state
  logic [WIDTH-1:0] act_q, act_d;
  logic [WIDTH-1:0] dy_q, dy_d;

  logic [WIDTH-1:0]   abs_x;
  logic [1:0]         seg_x;
  logic [WIDTH-1:0]   p;
  logic [2*WIDTH-1:0] prod;
  logic               unused_prod;

  // |x| with the most negative code clamped so it stays representable.
  always_comb begin
    if (x == MOST_NEG) begin
      abs_x = MAX_POS;
    end else if (x[WIDTH-1]) begin
      abs_x = -x;
    end else begin
      abs_x = x;
    end
    if (abs_x >= THR_S3) begin
      seg_x = SEG_S3;
    end else if (abs_x >= THR_S2) begin
      seg_x = SEG_S2;
    end else if (abs_x >= THR_S1) begin
      seg_x = SEG_S1;
    end else begin
      seg_x = SEG_S0;
    end
  end

  assign sat = (seg_x == SEG_S3);

  always_comb begin
    sign_d = sign_q;
    a_d    = a_q;
    seg_d  = seg_q;
    if (adv) begin
      sign_d = x[WIDTH-1];
      a_d    = abs_x;
      seg_d  = seg_x;
    end
  end

  // Piecewise-linear curve on |x|; negative inputs use the symmetry 1 - sigma(|x|).
  always_comb begin
    case (seg_q)
      SEG_S0:  p = (a_q >> 2) + OFF_S0;
      SEG_S1:  p = (a_q >> 3) + OFF_S1;
      SEG_S2:  p = (a_q >> 5) + OFF_S2;
      default: p = ONE;
    endcase
    y2_d = y2_q;
    if (adv) begin
      y2_d = sign_q ? (ONE - p) : p;
    end
  end

  // y lies in 0..ONE, so y*(ONE-y) >> FRAC never exceeds ONE/4 and fits in WIDTH bits.
  always_comb begin
    prod  = {{WIDTH{1'b0}}, y2_q} * {{WIDTH{1'b0}}, ONE - y2_q};
    act_d = act_q;
    dy_d  = dy_q;
    if (adv) begin
      act_d = y2_q;
      dy_d  = prod[FRAC +: WIDTH];
    end
  end

  assign unused_prod = ^{prod[2*WIDTH-1:FRAC+WIDTH], prod[FRAC-1:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      sign_q <= 1'b0;
      a_q    <= '0;
      seg_q  <= SEG_S0;
      y2_q   <= '0;
      act_q  <= '0;
      dy_q   <= '0;
    end else begin
      sign_q <= sign_d;
      a_q    <= a_d;
      seg_q  <= seg_d;
      y2_q   <= y2_d;
      act_q  <= act_d;
      dy_q   <= dy_d;
    end
  end

  assign y  = act_q;
  assign dy = dy_q;

endmodule

// File: rtl/sigmoid_pipe_array.sv
// CH-lane sigmoid / sigmoid-prime pipeline with beat-level valid/ready and saturation stats.
// Latency: 3 cycles accept-to-out_valid, 1 beat/cycle sustained.
// Backpressure: in_ready = !out_valid | out_ready; the whole pipe freezes while it is low.
// Ports: clk, rst (sync, active high); in_valid/in_ready/in_data (CH x WIDTH, lane i at i*WIDTH);
//        out_valid/out_ready, act_out, prime_out (same packing); sat_count (saturating).
module sigmoid_pipe_array
  import sigmoid_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int FRAC  = 12,
  parameter int CH    = 4,
  parameter int CNT_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [CH*WIDTH-1:0] in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [CH*WIDTH-1:0] act_out,
  output logic [CH*WIDTH-1:0] prime_out,
  output logic [CNT_W-1:0]    sat_count
);

  if ((FRAC < 3) || (WIDTH - FRAC < 4)) begin : g_bad_params
    $error("sigmoid_pipe_array: need FRAC >= 3 and WIDTH-FRAC >= 4");
  end

  logic             adv;
  logic             accept;
  logic [CH-1:0]    lane_sat;
  logic             v1_q, v1_d;
  logic             v2_q, v2_d;
  logic             v3_q, v3_d;
  logic [CNT_W-1:0] sat_cnt_q, sat_cnt_d;

  // A stalled output blocks the entire pipe, bubbles included, so all lanes stay aligned.
  assign adv      = !v3_q || out_ready;
  assign in_ready = adv;
  assign accept   = in_valid && adv;

  always_comb begin
    v1_d = v1_q;
    v2_d = v2_q;
    v3_d = v3_q;
    if (adv) begin
      v1_d = in_valid;
      v2_d = v1_q;
      v3_d = v2_q;
    end
    sat_cnt_d = sat_cnt_q;
    if (accept && (|lane_sat) && (sat_cnt_q != {CNT_W{1'b1}})) begin
      sat_cnt_d = sat_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q      <= 1'b0;
      v2_q      <= 1'b0;
      v3_q      <= 1'b0;
      sat_cnt_q <= '0;
    end else begin
      v1_q      <= v1_d;
      v2_q      <= v2_d;
      v3_q      <= v3_d;
      sat_cnt_q <= sat_cnt_d;
    end
  end

  for (genvar i = 0; i < CH; i++) begin : g_lane
    sigmoid_plan_lane #(
      .WIDTH(WIDTH),
      .FRAC (FRAC)
    ) u_lane (
      .clk(clk),
      .rst(rst),
      .adv(adv),
      .x  (in_data[i*WIDTH +: WIDTH]),
      .y  (act_out[i*WIDTH +: WIDTH]),
      .dy (prime_out[i*WIDTH +: WIDTH]),
      .sat(lane_sat[i])
    );
  end

  assign out_valid = v3_q;
  assign sat_count = sat_cnt_q;

endmodule

// File: tb/tb_sigmoid_pipe_array.sv
module tb_sigmoid_pipe_array;
  localparam int W     = 16;
  localparam int FRAC  = 12;
  localparam int CH    = 4;
  localparam int CNT_W = 16;
  localparam int ONE   = 1 << FRAC;

  logic clk = 1'b0;
  logic rst, in_valid, out_ready;
  logic [CH*W-1:0] in_data;
  logic in_ready, out_valid;
  logic [CH*W-1:0] act_out, prime_out;
  logic [CNT_W-1:0] sat_count;
  logic s_in_ready, s_out_valid;
  logic [CH*W-1:0] s_act, s_prime;
  logic [3:0] s_sat_count;

  always #5 clk = ~clk;

  sigmoid_pipe_array #(.WIDTH(W), .FRAC(FRAC), .CH(CH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .act_out(act_out), .prime_out(prime_out),
    .sat_count(sat_count));

  // Narrow-counter build sharing the same stimulus, used for the counter ceiling.
  sigmoid_pipe_array #(.WIDTH(W), .FRAC(FRAC), .CH(CH), .CNT_W(4)) dut_w4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready), .in_data(in_data),
    .out_valid(s_out_valid), .out_ready(out_ready), .act_out(s_act), .prime_out(s_prime),
    .sat_count(s_sat_count));

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model (plain arithmetic on the curve definition) -------------
  function automatic int ref_act(input logic [W-1:0] xr);
    int x, a, p;
    x = $signed(xr);
    a = (x < 0) ? -x : x;
    if (a > (1 << (W-1)) - 1) a = (1 << (W-1)) - 1;
    if (a >= 5*ONE)            p = ONE;
    else if (a*8 >= 19*ONE)    p = a/32 + (27*ONE)/32;
    else if (a >= ONE)         p = a/8 + (5*ONE)/8;
    else                       p = a/4 + ONE/2;
    return (x < 0) ? ONE - p : p;
  endfunction

  function automatic int ref_prime(input int y);
    return (y * (ONE - y)) / ONE;
  endfunction

  function automatic bit ref_sat(input logic [CH*W-1:0] d);
    int x;
    bit s = 0;
    for (int i = 0; i < CH; i++) begin
      x = $signed(d[i*W +: W]);
      if (x >= 5*ONE || x <= -5*ONE) s = 1;
    end
    return s;
  endfunction

  typedef struct { logic [CH*W-1:0] act; logic [CH*W-1:0] prime; } beat_t;

  function automatic beat_t model_beat(input logic [CH*W-1:0] d);
    beat_t b;
    int y;
    for (int i = 0; i < CH; i++) begin
      y = ref_act(d[i*W +: W]);
      b.act[i*W +: W]   = W'(y);
      b.prime[i*W +: W] = W'(ref_prime(y));
    end
    return b;
  endfunction

  function automatic logic [CH*W-1:0] rand_beat();
    logic [CH*W-1:0] d;
    int m;
    for (int i = 0; i < CH; i++) begin
      if ($urandom_range(3) == 0) d[i*W +: W] = W'($urandom);
      else begin
        m = $urandom_range(6*ONE);
        d[i*W +: W] = W'($urandom_range(1) ? -m : m);
      end
    end
    return d;
  endfunction

  // ---------------- scoreboard monitor (samples at negedge) ----------------
  beat_t sb_q[$];
  int exp_sat = 0;
  int rx_cnt  = 0;
  bit mon_en  = 0;

  always @(negedge clk) begin
    if (mon_en) begin
      chk("sat_count", sat_count, exp_sat);
      chk("sat_count_w4", s_sat_count, (exp_sat > 15) ? 15 : exp_sat);
      if (out_valid) begin
        chk("beat_expected", sb_q.size() > 0, 1);
        if (sb_q.size() > 0) begin
          chk("sb_act", act_out, sb_q[0].act);
          chk("sb_prime", prime_out, sb_q[0].prime);
          if (out_ready && !rst) begin
            void'(sb_q.pop_front());
            rx_cnt++;
          end
        end
      end
      if (rst) begin
        sb_q.delete();
        exp_sat = 0;
      end else if (in_valid && in_ready) begin
        sb_q.push_back(model_beat(in_data));
        if (ref_sat(in_data)) exp_sat++;
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [CH*W-1:0] d);
    int waited;
    waited = 0;
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    while (!in_ready && waited < 50) begin
      waited++;
      @(negedge clk);
    end
    chk("send_accept", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int waited;
    waited = 0;
    out_ready = 1'b1;
    while (sb_q.size() != 0 && waited < 100) begin
      waited++;
      tick();
    end
    chk("drain_empty", sb_q.size(), 0);
  endtask

  typedef struct { logic [CH*W-1:0] din; logic [CH*W-1:0] act; logic [CH*W-1:0] prime; } vec_t;
  vec_t tbl[8];

  function automatic vec_t mk(input logic [W-1:0] x, input logic [W-1:0] a, input logic [W-1:0] p);
    vec_t v;
    v.din   = {{(CH-1)*W{1'b0}}, x};
    v.act   = {{(CH-1){16'h0800}}, a};
    v.prime = {{(CH-1){16'h0400}}, p};
    return v;
  endfunction

  logic [CH*W-1:0] hold;
  int rx0, sat0;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = mk(16'h0000, 16'h0800, 16'h0400);
    tbl[1] = mk(16'h1000, 16'h0C00, 16'h0300);
    tbl[2] = mk(16'hF000, 16'h0400, 16'h0300);
    tbl[3] = mk(16'h5000, 16'h1000, 16'h0000);
    tbl[4] = mk(16'hB000, 16'h0000, 16'h0000);
    tbl[5] = mk(16'h8000, 16'h0000, 16'h0000);
    tbl[6] = mk(16'h7FFF, 16'h1000, 16'h0000);
    tbl[7].din   = {16'h0400, 16'hE000, 16'h2600, 16'h2000};
    tbl[7].act   = {16'h0900, 16'h0200, 16'h0EB0, 16'h0E00};
    tbl[7].prime = {16'h03F0, 16'h01C0, 16'h0134, 16'h01C0};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; in_data = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_act", act_out, 0);
    chk("rst_prime", prime_out, 0);
    chk("rst_sat", sat_count, 0);
    chk("rst_in_ready", in_ready, 1);
    tick();

    // Table vectors streamed back to back, collected in order.
    sat0 = sat_count;
    fork
      begin
        for (int i = 0; i < 8; i++) send(tbl[i].din);
      end
      begin
        for (int k = 0; k < 8; k++) begin
          int w;
          w = 0;
          @(negedge clk);
          while (!(out_valid && out_ready) && w < 50) begin
            w++;
            @(negedge clk);
          end
          chk($sformatf("tbl%0d_act", k), act_out, tbl[k].act);
          chk($sformatf("tbl%0d_prime", k), prime_out, tbl[k].prime);
        end
      end
    join
    tick();
    chk("tbl_sat_delta", sat_count - sat0, 4);
    drain();

    // Ten-beat stream with a three-cycle output stall.
    rx0 = rx_cnt;
    fork
      begin
        for (int i = 0; i < 10; i++) send(rand_beat());
      end
      begin
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
          @(negedge clk);
          if (c == 0) hold = act_out;
          chk("stall_out_valid", out_valid, 1);
          chk("stall_in_ready", in_ready, 0);
          if (c > 0) chk("stall_hold", act_out, hold);
        end
        @(posedge clk); #1 out_ready = 1'b1;
      end
    join
    drain();
    chk("stream_count", rx_cnt - rx0, 10);

    // Random traffic with random backpressure.
    for (int i = 0; i < 300; i++) begin
      in_valid  = ($urandom_range(3) != 0);
      in_data   = rand_beat();
      out_ready = ($urandom_range(2) != 0);
      tick();
    end
    in_valid = 1'b0;
    drain();

    // Reset with three beats in flight.
    for (int i = 0; i < 3; i++) send(rand_beat());
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_act", act_out, 0);
    chk("midrst_prime", prime_out, 0);
    chk("midrst_sat", sat_count, 0);
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_data  = {16'h0400, 16'hE000, 16'h2600, 16'h2000};
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      chk($sformatf("postrst_lat_c%0d", c), out_valid, c == 3);
    end
    chk("postrst_act", act_out, {16'h0900, 16'h0200, 16'h0EB0, 16'h0E00});
    tick();
    drain();

    // Counter ceiling: 2^4+5 saturating beats.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 21; i++) begin
      logic [CH*W-1:0] d;
      d = rand_beat();
      d[W-1:0] = ($urandom_range(1) != 0) ? 16'h5000 : 16'h8000;
      send(d);
    end
    tick();
    chk("w4_sat_hold", s_sat_count, 4'hF);
    chk("w16_sat_21", sat_count, 21);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
